// File: rtl/tl_master_socket.sv
// Per-master TileLink-UL socket: buffered A/D paths, outstanding limit, post-issue idle gap.
// Optional build macro TL_SOCKET_CHK_EN enables A-head legality checks with local error responses.

module tl_socket_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             full,
  output logic             not_empty,
  output logic [WIDTH-1:0] rd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  // Full is taken from the registered count, so a write while full is refused even if a read happens.
  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  assign wr_en     = wr_valid && !full;
  assign rd_en     = rd_ready && not_empty;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module tl_master_socket #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int SRC_WIDTH       = 2,
  parameter int SINK_WIDTH      = 1,
  parameter int OPCODE_WIDTH    = 3,
  parameter int PARAM_WIDTH     = 3,
  parameter int MASTER_ID       = 0,
  parameter int A_DEPTH         = 2,
  parameter int D_DEPTH         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 h_a_valid,
  output logic                                 h_a_ready,
  input  logic [OPCODE_WIDTH-1:0]              h_a_opcode,
  input  logic [PARAM_WIDTH-1:0]               h_a_param,
  input  logic [SIZE_WIDTH-1:0]                h_a_size,
  input  logic [ADDR_WIDTH-1:0]                h_a_address,
  input  logic [MASK_WIDTH-1:0]                h_a_mask,
  input  logic [DATA_WIDTH-1:0]                h_a_data,
  output logic                                 x_a_valid,
  input  logic                                 x_a_ready,
  output logic [OPCODE_WIDTH-1:0]              x_a_opcode,
  output logic [PARAM_WIDTH-1:0]               x_a_param,
  output logic [SIZE_WIDTH-1:0]                x_a_size,
  output logic [SRC_WIDTH-1:0]                 x_a_source,
  output logic [ADDR_WIDTH-1:0]                x_a_address,
  output logic [MASK_WIDTH-1:0]                x_a_mask,
  output logic [DATA_WIDTH-1:0]                x_a_data,
  input  logic                                 x_d_valid,
  output logic                                 x_d_ready,
  input  logic [OPCODE_WIDTH-1:0]              x_d_opcode,
  input  logic [PARAM_WIDTH-1:0]               x_d_param,
  input  logic [SIZE_WIDTH-1:0]                x_d_size,
  input  logic [SRC_WIDTH-1:0]                 x_d_source,
  input  logic [SINK_WIDTH-1:0]                x_d_sink,
  input  logic [DATA_WIDTH-1:0]                x_d_data,
  input  logic                                 x_d_error,
  output logic                                 h_d_valid,
  input  logic                                 h_d_ready,
  output logic [OPCODE_WIDTH-1:0]              h_d_opcode,
  output logic [PARAM_WIDTH-1:0]               h_d_param,
  output logic [SIZE_WIDTH-1:0]                h_d_size,
  output logic [SRC_WIDTH-1:0]                 h_d_source,
  output logic [SINK_WIDTH-1:0]                h_d_sink,
  output logic [DATA_WIDTH-1:0]                h_d_data,
  output logic                                 h_d_error,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int AW = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;
  localparam int DW = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH + SINK_WIDTH + DATA_WIDTH + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  logic          a_full, a_not_empty, a_pop, a_wr;
  logic [AW-1:0] a_head;
  logic          d_full, d_not_empty, d_wr, d_pop;
  logic [DW-1:0] d_wdata, d_head;
  logic          x_d_wr;
  logic          x_a_hs, h_d_hs;
  logic          head_ok;
  logic          local_pop;
  logic          gap;

  assign h_a_ready = !reset && !a_full;
  assign a_wr      = h_a_valid && h_a_ready;
  assign x_a_hs    = x_a_valid && x_a_ready;
  assign a_pop     = x_a_hs || local_pop;

  tl_socket_fifo #(.WIDTH(AW), .DEPTH(A_DEPTH)) u_a_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (a_wr),
    .wr_data   ({h_a_opcode, h_a_param, h_a_size, h_a_address, h_a_mask, h_a_data}),
    .rd_ready  (a_pop),
    .full      (a_full),
    .not_empty (a_not_empty),
    .rd_data   (a_head)
  );

  assign {x_a_opcode, x_a_param, x_a_size, x_a_address, x_a_mask, x_a_data} = a_head;
  assign x_a_source = SRC_WIDTH'(MASTER_ID);
  assign x_a_valid  = !reset && a_not_empty && head_ok && (outstanding < MAX_OUT) && !gap;

  assign x_d_ready = !reset && !d_full;
  assign x_d_wr    = x_d_valid && x_d_ready;
  assign h_d_hs    = h_d_valid && h_d_ready;
  assign d_pop     = h_d_hs;
  assign d_wr      = x_d_wr || local_pop;

`ifdef TL_SOCKET_CHK_EN
  localparam int LG_BYTES = $clog2(MASK_WIDTH);

  function automatic logic head_legal(input logic [OPCODE_WIDTH-1:0] op,
                                      input logic [SIZE_WIDTH-1:0]   sz,
                                      input logic [ADDR_WIDTH-1:0]   addr);
    logic ok;
    ok = (op == OPCODE_WIDTH'(0)) || (op == OPCODE_WIDTH'(1)) || (op == OPCODE_WIDTH'(4));
    if (sz > SIZE_WIDTH'(LG_BYTES)) begin
      ok = 1'b0;
    end
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if ((i < int'(sz)) && addr[i]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  logic [OPCODE_WIDTH-1:0] local_opcode;

  assign head_ok      = head_legal(x_a_opcode, x_a_size, x_a_address);
  // Crossbar responses win the D FIFO write port; the local error response waits for a free slot.
  assign local_pop    = !reset && a_not_empty && !head_ok && !x_d_wr && !d_full;
  assign local_opcode = (x_a_opcode == OPCODE_WIDTH'(4)) ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
  assign d_wdata      = x_d_wr ? {x_d_opcode, x_d_param, x_d_size, x_d_source, x_d_sink, x_d_data, x_d_error}
                               : {local_opcode, x_a_param, x_a_size, SRC_WIDTH'(MASTER_ID),
                                  {SINK_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, 1'b1};
`else
  assign head_ok   = 1'b1;
  assign local_pop = 1'b0;
  assign d_wdata   = {x_d_opcode, x_d_param, x_d_size, x_d_source, x_d_sink, x_d_data, x_d_error};
`endif

  tl_socket_fifo #(.WIDTH(DW), .DEPTH(D_DEPTH)) u_d_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (d_wr),
    .wr_data   (d_wdata),
    .rd_ready  (d_pop),
    .full      (d_full),
    .not_empty (d_not_empty),
    .rd_data   (d_head)
  );

  assign {h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_sink, h_d_data, h_d_error} = d_head;
  assign h_d_valid = !reset && d_not_empty;

  // Gap drops x_a_valid for one cycle after each issue so the crossbar arbiter sees a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap         <= 1'b0;
      outstanding <= '0;
    end else begin
      gap <= x_a_hs;
      case ({x_a_hs, h_d_hs && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_master_socket.sv
// Directed bench for tl_master_socket: scoreboard queues for A and D beats, monitor on negedge.
module tb_tl_master_socket;
  localparam int MID = 1;
  localparam int AXW = 3 + 3 + 3 + 2 + 32 + 4 + 32;
  localparam int DW  = 3 + 3 + 3 + 2 + 1 + 32 + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        h_a_valid, h_a_ready;
  logic [2:0]  h_a_opcode, h_a_param, h_a_size;
  logic [31:0] h_a_address;
  logic [3:0]  h_a_mask;
  logic [31:0] h_a_data;
  logic        x_a_valid, x_a_ready;
  logic [2:0]  x_a_opcode, x_a_param, x_a_size;
  logic [1:0]  x_a_source;
  logic [31:0] x_a_address;
  logic [3:0]  x_a_mask;
  logic [31:0] x_a_data;
  logic        x_d_valid, x_d_ready;
  logic [2:0]  x_d_opcode, x_d_param, x_d_size;
  logic [1:0]  x_d_source;
  logic [0:0]  x_d_sink;
  logic [31:0] x_d_data;
  logic        x_d_error;
  logic        h_d_valid, h_d_ready;
  logic [2:0]  h_d_opcode, h_d_param, h_d_size;
  logic [1:0]  h_d_source;
  logic [0:0]  h_d_sink;
  logic [31:0] h_d_data;
  logic        h_d_error;
  logic [1:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AXW-1:0] a_exp_q[$];
  logic [DW-1:0]  d_exp_q[$];

  always #5 clk = ~clk;

  tl_master_socket #(.MASTER_ID(MID)) dut (
    .clk(clk), .reset(reset),
    .h_a_valid(h_a_valid), .h_a_ready(h_a_ready), .h_a_opcode(h_a_opcode), .h_a_param(h_a_param),
    .h_a_size(h_a_size), .h_a_address(h_a_address), .h_a_mask(h_a_mask), .h_a_data(h_a_data),
    .x_a_valid(x_a_valid), .x_a_ready(x_a_ready), .x_a_opcode(x_a_opcode), .x_a_param(x_a_param),
    .x_a_size(x_a_size), .x_a_source(x_a_source), .x_a_address(x_a_address), .x_a_mask(x_a_mask),
    .x_a_data(x_a_data),
    .x_d_valid(x_d_valid), .x_d_ready(x_d_ready), .x_d_opcode(x_d_opcode), .x_d_param(x_d_param),
    .x_d_size(x_d_size), .x_d_source(x_d_source), .x_d_sink(x_d_sink), .x_d_data(x_d_data),
    .x_d_error(x_d_error),
    .h_d_valid(h_d_valid), .h_d_ready(h_d_ready), .h_d_opcode(h_d_opcode), .h_d_param(h_d_param),
    .h_d_size(h_d_size), .h_d_source(h_d_source), .h_d_sink(h_d_sink), .h_d_data(h_d_data),
    .h_d_error(h_d_error),
    .outstanding(outstanding)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed handshake is compared against the head of its scoreboard queue.
  always @(negedge clk) begin
    if (x_a_valid && x_a_ready) begin
      n_checks++;
      if (a_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL x_a_beat: unexpected beat addr 0x%0h", x_a_address);
      end else begin
        logic [AXW-1:0] e;
        e = a_exp_q.pop_front();
        if ({x_a_opcode, x_a_param, x_a_size, x_a_source, x_a_address, x_a_mask, x_a_data} !== e) begin
          n_fail++;
          $display("FAIL x_a_beat: got 0x%0h, expected 0x%0h",
                   {x_a_opcode, x_a_param, x_a_size, x_a_source, x_a_address, x_a_mask, x_a_data}, e);
        end
      end
    end
    if (h_d_valid && h_d_ready) begin
      n_checks++;
      if (d_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL h_d_beat: unexpected beat data 0x%0h", h_d_data);
      end else begin
        logic [DW-1:0] e;
        e = d_exp_q.pop_front();
        if ({h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_sink, h_d_data, h_d_error} !== e) begin
          n_fail++;
          $display("FAIL h_d_beat: got 0x%0h, expected 0x%0h",
                   {h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_sink, h_d_data, h_d_error}, e);
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic host_a(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [31:0] data, input bit expect_issue);
    h_a_valid = 1'b1; h_a_opcode = op; h_a_param = 3'd0; h_a_size = sz;
    h_a_address = addr; h_a_mask = 4'hF; h_a_data = data;
    if (expect_issue) a_exp_q.push_back({op, 3'd0, sz, 2'(MID), addr, 4'hF, data});
  endtask

  task automatic xbar_d(input logic [2:0] op, input logic [31:0] data, input bit expect_out);
    x_d_valid = 1'b1; x_d_opcode = op; x_d_param = 3'd0; x_d_size = 3'd2;
    x_d_source = 2'(MID); x_d_sink = 1'b1; x_d_data = data; x_d_error = 1'b0;
    if (expect_out) d_exp_q.push_back({op, 3'd0, 3'd2, 2'(MID), 1'b1, data, 1'b0});
  endtask

  initial begin
    reset = 1'b1; h_a_valid = 1'b0; h_a_opcode = 3'd0; h_a_param = 3'd0; h_a_size = 3'd0;
    h_a_address = 32'd0; h_a_mask = 4'd0; h_a_data = 32'd0; x_a_ready = 1'b0;
    x_d_valid = 1'b0; x_d_opcode = 3'd0; x_d_param = 3'd0; x_d_size = 3'd0; x_d_source = 2'd0;
    x_d_sink = 1'b0; x_d_data = 32'd0; x_d_error = 1'b0; h_d_ready = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_h_a_ready", 64'(h_a_ready), 64'd0);
    chk("rst_x_d_ready", 64'(x_d_ready), 64'd0);
    reset = 1'b0; settle();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_h_a_ready_rel", 64'(h_a_ready), 64'd1);
    chk("rst_x_a_valid", 64'(x_a_valid), 64'd0);

    // Single Get at 0x100
    x_a_ready = 1'b1; host_a(3'd4, 32'h100, 3'd2, 32'd0, 1'b1); settle();
    chk("get_x_a_valid_c0", 64'(x_a_valid), 64'd0);
    cyc(); h_a_valid = 1'b0; settle();
    chk("get_x_a_valid_c1", 64'(x_a_valid), 64'd1);
    chk("get_x_a_source", 64'(x_a_source), 64'(MID));
    chk("get_outstanding_c1", 64'(outstanding), 64'd0);
    cyc();
    chk("get_gap", 64'(x_a_valid), 64'd0);
    chk("get_outstanding_c2", 64'(outstanding), 64'd1);
    h_d_ready = 1'b1; xbar_d(3'd1, 32'h1234_5678, 1'b1);
    cyc(); x_d_valid = 1'b0; settle();
    chk("get_h_d_valid", 64'(h_d_valid), 64'd1);
    cyc();
    chk("get_outstanding_back0", 64'(outstanding), 64'd0);
    h_d_ready = 1'b0;

    // Three PutFull beats, limit 2
    host_a(3'd0, 32'h200, 3'd2, 32'h1111_1111, 1'b1); settle();
    chk("b2b_ready_k0", 64'(h_a_ready), 64'd1);
    cyc(); host_a(3'd0, 32'h204, 3'd2, 32'h2222_2222, 1'b1); settle();
    chk("b2b_ready_k1", 64'(h_a_ready), 64'd1);
    chk("b2b_valid_k1", 64'(x_a_valid), 64'd1);
    cyc(); host_a(3'd0, 32'h208, 3'd2, 32'h3333_3333, 1'b1); settle();
    chk("b2b_ready_k2", 64'(h_a_ready), 64'd1);
    chk("b2b_valid_k2", 64'(x_a_valid), 64'd0);
    cyc(); h_a_valid = 1'b0; settle();
    chk("b2b_ready_full", 64'(h_a_ready), 64'd0);
    chk("b2b_valid_k3", 64'(x_a_valid), 64'd1);
    cyc();
    chk("b2b_valid_k4", 64'(x_a_valid), 64'd0);
    chk("b2b_outstanding", 64'(outstanding), 64'd2);
    cyc();
    chk("b2b_held_at_limit", 64'(x_a_valid), 64'd0);
    chk("b2b_ready_k5", 64'(h_a_ready), 64'd1);

    // AccessAckData held under back-pressure
    x_a_ready = 1'b0; xbar_d(3'd1, 32'hDEAD_BEEF, 1'b1);
    cyc(); x_d_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_h_d_valid", 64'(h_d_valid), 64'd1);
      chk("hold_h_d_data", 64'(h_d_data), 64'hDEAD_BEEF);
      chk("hold_outstanding", 64'(outstanding), 64'd2);
      cyc();
    end
    h_d_ready = 1'b1;
    cyc(); h_d_ready = 1'b0; settle();
    chk("hold_dec", 64'(outstanding), 64'd1);
    chk("third_valid", 64'(x_a_valid), 64'd1);
    chk("third_addr", 64'(x_a_address), 64'h208);
    cyc();
    chk("third_addr_stable", 64'(x_a_address), 64'h208);
    x_a_ready = 1'b1;
    cyc(); x_a_ready = 1'b0; settle();
    chk("third_issued", 64'(outstanding), 64'd2);
    chk("third_gap", 64'(x_a_valid), 64'd0);

    // Fill D FIFO, then drain
    xbar_d(3'd0, 32'h0, 1'b1); settle();
    chk("dfill_ready_m0", 64'(x_d_ready), 64'd1);
    cyc(); xbar_d(3'd1, 32'hCAFE_0001, 1'b1); settle();
    chk("dfill_ready_m1", 64'(x_d_ready), 64'd1);
    cyc(); x_d_valid = 1'b0; settle();
    chk("dfill_full", 64'(x_d_ready), 64'd0);
    cyc(); h_d_ready = 1'b1; settle();
    chk("dfill_full_pop_cycle", 64'(x_d_ready), 64'd0);
    cyc();
    chk("dfill_ready_after_pop", 64'(x_d_ready), 64'd1);
    cyc(); h_d_ready = 1'b0; settle();
    chk("dfill_outstanding", 64'(outstanding), 64'd0);
    chk("dfill_empty", 64'(h_d_valid), 64'd0);

    // Reset with buffered beats
    host_a(3'd4, 32'h300, 3'd2, 32'd0, 1'b0);
    cyc(); host_a(3'd4, 32'h304, 3'd2, 32'd0, 1'b0);
    cyc(); h_a_valid = 1'b0; xbar_d(3'd1, 32'hBAD0_BAD0, 1'b0);
    cyc(); x_d_valid = 1'b0; settle();
    chk("pre_rst_x_a_valid", 64'(x_a_valid), 64'd1);
    chk("pre_rst_h_d_valid", 64'(h_d_valid), 64'd1);
    reset = 1'b1; settle();
    chk("mid_rst_x_a_valid", 64'(x_a_valid), 64'd0);
    chk("mid_rst_h_d_valid", 64'(h_d_valid), 64'd0);
    chk("mid_rst_h_a_ready", 64'(h_a_ready), 64'd0);
    chk("mid_rst_x_d_ready", 64'(x_d_ready), 64'd0);
    cyc(); reset = 1'b0; x_a_ready = 1'b1; h_d_ready = 1'b1; settle();
    chk("post_rst_outstanding", 64'(outstanding), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_stale", 64'({x_a_valid, h_d_valid}), 64'd0);
      cyc();
    end

`ifdef TL_SOCKET_CHK_EN
    // Illegal opcode becomes a local error response
    host_a(3'd2, 32'h102, 3'd2, 32'd0, 1'b0);
    d_exp_q.push_back({3'd0, 3'd0, 3'd2, 2'(MID), 1'b0, 32'd0, 1'b1});
    cyc(); h_a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("chk_no_x_a_valid", 64'(x_a_valid), 64'd0);
      chk("chk_outstanding", 64'(outstanding), 64'd0);
      cyc();
    end
`endif

    // Everything expected must have been observed
    for (int i = 0; i < 50 && (a_exp_q.size() != 0 || d_exp_q.size() != 0); i++) cyc();
    chk("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
    chk("d_queue_drained", 64'(d_exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tl_master_socket.md
Name: tl_master_socket

Overview:
- Per-master TileLink-UL socket sitting directly upstream of the main crossbar; one instance per crossbar master port.
- Buffers host A-channel requests and drives them to the crossbar with source = MASTER_ID.
- Buffers returning D-channel responses and enforces a maximum number of outstanding requests.
- Inserts the mandatory idle cycle after every accepted A beat so the crossbar's valid-falling-edge arbiter releases the port.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, byte mask width
- SIZE_WIDTH, 3, log2 transfer size width
- SRC_WIDTH, 2, source ID width
- SINK_WIDTH, 1, sink ID width
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- MASTER_ID, 0, crossbar port index driven on x_a_source
- A_DEPTH, 2, A request FIFO entries (power of 2, ≥2)
- D_DEPTH, 2, D response FIFO entries (power of 2, must be ≥ MAX_OUTSTANDING)
- MAX_OUTSTANDING, 2, limit on issued-but-undelivered requests (1..2^SRC_WIDTH)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- h_a_valid / h_a_ready  in / out  1  host A handshake
- h_a_opcode, h_a_param, h_a_size, h_a_address, h_a_mask, h_a_data  in  OPCODE/PARAM/SIZE/ADDR/MASK/DATA_WIDTH  host A payload
- x_a_valid / x_a_ready  out / in  1  crossbar A handshake
- x_a_opcode, x_a_param, x_a_size, x_a_source, x_a_address, x_a_mask, x_a_data  out  matching widths  crossbar A payload
- x_d_valid / x_d_ready  in / out  1  crossbar D handshake
- x_d_opcode, x_d_param, x_d_size, x_d_source, x_d_sink, x_d_data, x_d_error  in  matching widths, error 1  crossbar D payload
- h_d_valid / h_d_ready  out / in  1  host D handshake
- h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_sink, h_d_data, h_d_error  out  matching widths  host D payload
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

Behaviour:
- Reset (sync, clk edge with reset=1): FIFOs empty, outstanding=0, gap flag=0. While reset is high: h_a_ready=0, x_a_valid=0, x_d_ready=0, h_d_valid=0. Reset mid-transfer discards all buffered beats with no further handshakes.
- A path:
  - h_a_ready = !A-FIFO full.
  - Host beat written on h_a_valid&&h_a_ready.
  - Latency: accepted beat visible on x_a_* the next cycle at the earliest.
- x_a_valid = A-FIFO non-empty && outstanding < MAX_OUTSTANDING && !gap.
  - x_a_source = MASTER_ID[SRC_WIDTH-1:0]; other fields come from the FIFO head.
  - Payload is stable while x_a_valid=1 and x_a_ready=0.
- Gap: a handshake on x_a_valid&&x_a_ready sets gap for exactly one cycle, forcing x_a_valid=0. Maximum issue rate is one beat per 2 cycles.
- Outstanding counter:
  - +1 on x_a handshake; -1 on h_d handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows. An h_d handshake at 0 (only possible as a local error response) does not decrement.
- D path:
  - x_d_ready = !D-FIFO full.
  - Beat written on x_d_valid&&x_d_ready; h_d_* is driven from the FIFO head, one-cycle latency.
  - All fields pass through unmodified, including h_d_source.
- FIFO simultaneous read+write while full: write is refused (ready reflects the registered full flag); read proceeds.
- FIFO simultaneous read+write while empty: the written entry appears next cycle.
- Pointers wrap modulo depth; the count register distinguishes full from empty.

Optional Feature:
- Macro: TL_SOCKET_CHK_EN.
- Defined:
  - An A-FIFO head is illegal if its opcode is not in {0 PutFull, 1 PutPartial, 4 Get}, or if the address is misaligned to 2^size bytes, or if size > log2(DATA_WIDTH/8).
  - An illegal head is popped without x_a issue and without an outstanding increment.
  - A local response is queued into the D FIFO: opcode 1 (AccessAckData) for Get, otherwise 0; d_error=1; source=MASTER_ID; sink=0; data=0; size and param copied.
  - x_d writes take priority; the local response waits while x_d writes or the D FIFO is full.
  - The next A head is not processed until the local response is queued.
- Undefined: no checking; every beat is forwarded.

Test Plan:
- Reset, then one Get at address 0x100, size 2, with x_a_ready=1 → x_a_valid rises 1 cycle after host accept, x_a_source=MASTER_ID, outstanding 0→1, and x_a_valid=0 on the following cycle.
- Three back-to-back host PutFull beats, x_a_ready=1, MAX_OUTSTANDING=2, no D responses → exactly 2 issued on alternating cycles, third held, outstanding=2, h_a_ready drops only when the A FIFO fills.
- Return an AccessAckData response (data 0xDEADBEEF) with h_d_ready=0 for 5 cycles → data held stable on h_d_*, outstanding stays 2, and decrements to 1 on the h_d handshake.
- Fill the D FIFO (2 entries, h_d_ready=0) → x_d_ready=0. Raise h_d_ready → entries drain in order; x_d_ready=1 the cycle after the first pop.
- Assert reset with 2 queued A beats and 1 queued D beat → all valids low, outstanding=0; after release no stale beats appear.
- TL_SOCKET_CHK_EN: opcode 2 at address 0x102 size 2 → no x_a_valid; h_d_valid with h_d_error=1, h_d_opcode=0, h_d_source=MASTER_ID; outstanding remains 0.
